shift_load_controller: RTL and testbench
========================================

# shift_load_controller

Sequencer that drives the 4-bit serial shift register: accepts a parallel word over a valid/ready handshake, clears the register, and shifts the word in MSB-first at a programmable slow rate. It then reads back the register's parallel output and reports done or mismatch. It replaces the free-running slow clock with a single-clock shift-enable tick. It sits between the host/control logic and the shift-register datapath.

## Interface
- DIV_WIDTH, 24: width of the tick divider and of div_val.
- WORD_WIDTH, 4: shift register length in bits (bit counter sized $clog2(WORD_WIDTH)+1).
- clk  in  1  system clock; all state on rising edge.
- clr  in  1  reset, asynchronous, active-low.
- div_val  in  DIV_WIDTH  tick period minus 1; sampled only at word acceptance.
- wr_valid  in  1  host offers wr_data.
- wr_data  in  WORD_WIDTH  word to load.
- wr_ready  out  1  controller idle, can accept.
- abort  in  1  synchronous cancel of an in-flight load.
- sr_data  out  1  serial bit to shift register data input.
- sr_shift  out  1  one-cycle shift enable to shift register.
- sr_clear  out  1  one-cycle synchronous clear request to shift register, active-high.
- sr_q  in  WORD_WIDTH  shift register parallel readback.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse, load finished (match or mismatch).
- err  out  1  sticky mismatch flag; cleared on next accepted word.

## Operation
- States: IDLE, CLEAR, SHIFT, SETTLE, CHECK.
- IDLE: wr_ready=1. On wr_valid&wr_ready, latch wr_data into word_r, latch div_val into div_r, clear err, go to CLEAR.
- CLEAR: sr_clear=1 for exactly one cycle; divider count and bit count reset to 0; go to SHIFT.
- SHIFT: divider counts 0..div_r. tick = (count==div_r); count wraps to 0 on tick. On tick: sr_shift=1, sr_data=word_r[WORD_WIDTH-1-bitcnt], bitcnt++. After the WORD_WIDTH-th tick, go to SETTLE.
- sr_data holds the current bit throughout SHIFT (not only on tick). It is 0 outside SHIFT.
- Shift register contract: on sr_shift, data enters q[0] and shifts toward the MSB. After WORD_WIDTH shifts, sr_q == word_r.
- SETTLE: one idle cycle so sr_q reflects the last shift.
- CHECK: done=1; err <= (sr_q != word_r); go to IDLE.
- abort: in CLEAR/SHIFT/SETTLE, go to IDLE next cycle, assert sr_clear that cycle, no done, err unchanged. In CHECK, abort is ignored and the check completes. In IDLE, abort is ignored and a simultaneous wr_valid is accepted.
- div_val changes while busy have no effect until the next acceptance.
- div_val=0: tick every SHIFT cycle. div_val all-ones: full-range count, no overflow beyond wrap to 0.
- Reset (clr low, any time, including mid-shift): state=IDLE; counts, word_r, div_r = 0. Outputs: wr_ready=1, busy=0, done=0, err=0, sr_data=0, sr_shift=0, sr_clear=0. Recovery is on the first rising clk after clr deasserts.

## Timing
- All outputs are registered or decoded from state registers only; there is no combinational input-to-output path.
- Acceptance at edge 0 (D = div_r):
  - cycle 1: CLEAR, sr_clear=1.
  - shift k (k=0..3) in cycle 1+(D+1)(k+1).
  - SETTLE in cycle 2+4(D+1).
  - CHECK/done in cycle 3+4(D+1).
  - wr_ready=1 in cycle 4+4(D+1).
- D=0 example: shifts in cycles 2,3,4,5; done in cycle 7; next word accepted at edge ending cycle 8 at earliest.
- Throughput: one word per 4(D+1)+4 cycles.
- sr_shift never asserts in two consecutive cycles unless D=0.

## Structure
- Package shift_ctrl_pkg: state encoding localparams (IDLE, CLEAR, SHIFT, SETTLE, CHECK), WORD_WIDTH default, bit-count width constant.
- Sub-module tick_divider with ports clk, clr, restart, period, tick; it holds the DIV_WIDTH counter.
- The FSM, word/err registers and output decode stay in shift_load_controller.

## Test plan
- Reset: clr low mid-SHIFT with D=3 -> all outputs at reset values immediately; wr_ready=1 after release; no done.
- Basic load: D=0, wr_data=4'b1011 -> sr_clear in cycle 1; sr_shift in cycles 2-5 with sr_data 1,0,1,1; model sr_q=4'b1011; done in cycle 7; err=0.
- Slow rate: D=4, wr_data=4'b0110 -> sr_shift exactly every 5 cycles (cycles 6,11,16,21); done in cycle 23; div_val changed to 0 mid-load has no effect.
- Mismatch: D=0, wr_data=4'b1100, model forces sr_q=4'b1000 -> done in cycle 7, err=1. Next accept clears err; a clean load keeps err=0.
- Abort: D=2, abort after the second sr_shift -> next cycle IDLE with sr_clear=1; no done; wr_ready=1. Abort+wr_valid in IDLE -> word accepted.
- Back-to-back: wr_valid held high with 3 words, D=0 -> accepts spaced 8 cycles apart; 3 done pulses; wr_ready low throughout each busy period.

Source files
------------

// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the serial shift-register load sequencer.
package shift_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_SHIFT  = 3'd2,
    S_SETTLE = 3'd3,
    S_CHECK  = 3'd4
  } state_t;

  localparam int unsigned WORD_WIDTH_DEF = 4;
  localparam int unsigned DIV_WIDTH_DEF  = 24;
  localparam int unsigned BITCNT_W_DEF   = $clog2(WORD_WIDTH_DEF) + 1;

endpackage

// File: rtl/tick_divider.sv
// Programmable divider producing a one-cycle tick every period+1 cycles.
module tick_divider
  import shift_ctrl_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = DIV_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 restart,
  input  logic [DIV_WIDTH-1:0] period,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] count_q;
  logic [DIV_WIDTH-1:0] count_d;

  // tick is decoded from the counter register and the held period only
  always_comb begin
    tick    = (count_q == period);
    count_d = count_q + DIV_WIDTH'(1);
    if (restart || tick) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/shift_load_controller.sv
// Accepts a parallel word, clears the shift register, shifts the word in
// MSB-first at a programmable tick rate, then verifies the readback.
module shift_load_controller
  import shift_ctrl_pkg::*;
#(
  parameter int unsigned DIV_WIDTH  = DIV_WIDTH_DEF,
  parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [DIV_WIDTH-1:0]  div_val,
  input  logic                  wr_valid,
  input  logic [WORD_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  abort,
  output logic                  sr_data,
  output logic                  sr_shift,
  output logic                  sr_clear,
  input  logic [WORD_WIDTH-1:0] sr_q,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned     BCW      = $clog2(WORD_WIDTH) + 1;
  localparam logic [BCW-1:0]  LAST_BIT = BCW'(WORD_WIDTH - 1);

  state_t                state_q, state_d;
  logic [WORD_WIDTH-1:0] word_q, word_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [BCW-1:0]        bitcnt_q, bitcnt_d;
  logic                  err_q, err_d;
  logic                  abort_clr_q, abort_clr_d;
  logic                  tick;
  logic                  div_restart;
  logic [WORD_WIDTH-1:0] word_aligned;

  assign div_restart = (state_q != S_SHIFT);

  tick_divider #(.DIV_WIDTH(DIV_WIDTH)) u_tick_divider (
    .clk     (clk),
    .clr     (clr),
    .restart (div_restart),
    .period  (div_q),
    .tick    (tick)
  );

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    div_d       = div_q;
    bitcnt_d    = bitcnt_q;
    err_d       = err_q;
    abort_clr_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wr_valid) begin
          word_d  = wr_data;
          div_d   = div_val;
          err_d   = 1'b0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        bitcnt_d = '0;
        state_d  = S_SHIFT;
      end
      S_SHIFT: begin
        if (tick) begin
          bitcnt_d = bitcnt_q + BCW'(1);
          if (bitcnt_q == LAST_BIT) begin
            state_d = S_SETTLE;
          end
        end
      end
      S_SETTLE: state_d = S_CHECK;
      S_CHECK: begin
        err_d   = (sr_q != word_q);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Cancellation is only honoured before the check; the returning IDLE
    // cycle carries a registered clear so the register is left empty.
    if (abort && (state_q inside {S_CLEAR, S_SHIFT, S_SETTLE})) begin
      state_d     = S_IDLE;
      abort_clr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= S_IDLE;
      word_q      <= '0;
      div_q       <= '0;
      bitcnt_q    <= '0;
      err_q       <= 1'b0;
      abort_clr_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      div_q       <= div_d;
      bitcnt_q    <= bitcnt_d;
      err_q       <= err_d;
      abort_clr_q <= abort_clr_d;
    end
  end

  always_comb begin
    word_aligned = word_q << bitcnt_q;
    wr_ready     = (state_q == S_IDLE);
    busy         = (state_q != S_IDLE);
    sr_clear     = (state_q == S_CLEAR) || abort_clr_q;
    sr_shift     = (state_q == S_SHIFT) && tick;
    sr_data      = (state_q == S_SHIFT) ? word_aligned[WORD_WIDTH-1] : 1'b0;
    done         = (state_q == S_CHECK);
    err          = err_q;
  end

endmodule

// File: tb/tb_shift_load_controller.sv
// Self-checking bench: vector table plus scoreboard of expected shift,
// clear and done events, with a behavioural 4-bit shift register model.
module tb_shift_load_controller;

  typedef struct {
    int unsigned cyc;
    logic        v;
  } ev_t;

  typedef struct {
    logic [3:0]  data;
    int unsigned d;
    logic        mism;
    int unsigned abort_k;
    logic        idle_ab;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [23:0] div_val;
  logic        wr_valid, abort;
  logic [3:0]  wr_data;
  logic        wr_ready, sr_data, sr_shift, sr_clear, busy, done, err;
  logic [3:0]  sr_q, mdl_q;
  logic        force_en;

  int unsigned cyc = 0;
  int          passed = 0;
  int          total  = 0;
  int          done_seen = 0;

  int unsigned b_lo, b_hi, s_lo, s_hi, cur_d;
  logic [3:0]  cur_data;
  logic        exp_err, mon_en;
  ev_t         shift_q[$], done_q[$], clear_q[$];
  ev_t         mon_ev;
  logic        mon_got_done, mon_nxt_err, mon_exp_b, mon_exp_d;
  int unsigned mon_idx;
  vec_t        vecs[9];

  shift_load_controller #(.DIV_WIDTH(24), .WORD_WIDTH(4)) dut (
    .clk      (clk),
    .clr      (clr),
    .div_val  (div_val),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .abort    (abort),
    .sr_data  (sr_data),
    .sr_shift (sr_shift),
    .sr_clear (sr_clear),
    .sr_q     (sr_q),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // shift register model: data enters bit 0 and moves toward the MSB
  always @(posedge clk or negedge clr) begin
    if (!clr)          mdl_q <= 4'b0000;
    else if (sr_clear) mdl_q <= 4'b0000;
    else if (sr_shift) mdl_q <= {mdl_q[2:0], sr_data};
  end
  assign sr_q = force_en ? 4'b1000 : mdl_q;

  task automatic chk(input string name, input int act, input int exp_v);
    total++;
    if (act == exp_v) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_got_done = 1'b0;
      mon_nxt_err  = 1'b0;
      if (sr_shift) begin
        if (shift_q.size() == 0) chk("shift_unexpected", 1, 0);
        else begin
          mon_ev = shift_q.pop_front();
          chk("shift_cycle", int'(cyc), int'(mon_ev.cyc));
          chk("shift_bit", int'(sr_data), int'(mon_ev.v));
        end
      end
      if (sr_clear) begin
        if (clear_q.size() == 0) chk("clear_unexpected", 1, 0);
        else begin
          mon_ev = clear_q.pop_front();
          chk("clear_cycle", int'(cyc), int'(mon_ev.cyc));
        end
      end
      if (done) begin
        done_seen++;
        if (done_q.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          mon_ev = done_q.pop_front();
          chk("done_cycle", int'(cyc), int'(mon_ev.cyc));
          mon_got_done = 1'b1;
          mon_nxt_err  = mon_ev.v;
        end
      end
      mon_exp_b = (cyc >= b_lo) && (cyc <= b_hi);
      if ((cyc >= s_lo) && (cyc <= s_hi)) begin
        mon_idx   = (cyc - s_lo) / (cur_d + 1);
        mon_exp_d = cur_data[3 - mon_idx];
      end else begin
        mon_exp_d = 1'b0;
      end
      chk("busy", int'(busy), int'(mon_exp_b));
      chk("wr_ready", int'(wr_ready), int'(!mon_exp_b));
      chk("sr_data", int'(sr_data), int'(mon_exp_d));
      chk("err", int'(err), int'(exp_err));
      if (mon_got_done) exp_err = mon_nxt_err;
    end
  end

  // Expected events for a word accepted at the edge ending cycle base.
  task automatic arm(input int unsigned base, input logic [3:0] data, input int unsigned d,
                     input int unsigned abort_k, input logic exp_e);
    int unsigned chk_c, last, sh_end, sc;
    bit aborted;
    chk_c   = base + 3 + 4 * (d + 1);
    sh_end  = base + 1 + 4 * (d + 1);
    aborted = (abort_k != 0) && (abort_k < 3 + 4 * (d + 1));
    last    = aborted ? base + abort_k : chk_c;
    clear_q.push_back(ev_t'{base + 1, 1'b1});
    for (int unsigned k = 0; k < 4; k++) begin
      sc = base + 1 + (d + 1) * (k + 1);
      if (sc <= last) shift_q.push_back(ev_t'{sc, data[3 - k]});
    end
    if (aborted) clear_q.push_back(ev_t'{last + 1, 1'b1});
    else         done_q.push_back(ev_t'{chk_c, exp_e});
    b_lo     = base + 1;
    b_hi     = last;
    s_lo     = base + 2;
    s_hi     = (last < sh_end) ? last : sh_end;
    cur_d    = d;
    cur_data = data;
    exp_err  = 1'b0;
  endtask

  task automatic wait_until(input int unsigned c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_outputs(input string tag);
    chk({tag, "_wr_ready"}, int'(wr_ready), 1);
    chk({tag, "_busy"},     int'(busy), 0);
    chk({tag, "_done"},     int'(done), 0);
    chk({tag, "_err"},      int'(err), 0);
    chk({tag, "_sr_data"},  int'(sr_data), 0);
    chk({tag, "_sr_shift"}, int'(sr_shift), 0);
    chk({tag, "_sr_clear"}, int'(sr_clear), 0);
  endtask

  task automatic run_vec(input vec_t v);
    int unsigned base;
    wr_data  = v.data;
    div_val  = 24'(v.d);
    wr_valid = 1'b1;
    abort    = v.idle_ab;
    @(posedge clk);
    #1;
    base     = cyc - 1;
    wr_valid = 1'b0;
    abort    = 1'b0;
    div_val  = (v.d == 0) ? 24'd5 : 24'd0;
    wr_data  = ~v.data;
    force_en = v.mism;
    arm(base, v.data, v.d, v.abort_k, v.exp_err);
    if (v.abort_k != 0) begin
      wait_until(base + v.abort_k);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
    end
    wait_until(b_hi + 2);
    force_en = 1'b0;
    chk("drain", shift_q.size() + done_q.size() + clear_q.size(), 0);
  endtask

  initial begin
    int unsigned base;
    int          d0;
    logic [3:0]  w[3];

    vecs[0] = '{4'b1011, 0,  1'b0, 0, 1'b0, 1'b0};
    vecs[1] = '{4'b0110, 4,  1'b0, 0, 1'b0, 1'b0};
    vecs[2] = '{4'b1100, 0,  1'b1, 0, 1'b0, 1'b1};
    vecs[3] = '{4'b0101, 0,  1'b0, 0, 1'b0, 1'b0};
    vecs[4] = '{4'b1001, 2,  1'b0, 8, 1'b0, 1'b0};
    vecs[5] = '{4'b0011, 1,  1'b0, 0, 1'b1, 1'b0};
    vecs[6] = '{4'b1110, 0,  1'b1, 7, 1'b0, 1'b1};
    vecs[7] = '{4'b1010, 20, 1'b0, 0, 1'b0, 1'b0};
    vecs[8] = '{4'b0001, 3,  1'b0, 1, 1'b0, 1'b0};

    wr_valid = 1'b0;
    abort    = 1'b0;
    wr_data  = 4'h0;
    div_val  = 24'd0;
    force_en = 1'b0;
    mon_en   = 1'b0;
    exp_err  = 1'b0;
    b_lo = 1; b_hi = 0; s_lo = 1; s_hi = 0; cur_d = 0; cur_data = 4'h0;

    #1 clr = 1'b0;
    #1 reset_outputs("por");
    repeat (2) @(posedge clk);
    #3 clr = 1'b1;
    @(posedge clk);
    #1 mon_en = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // back-to-back: wr_valid held high across three words
    w[0] = 4'b1101; w[1] = 4'b0010; w[2] = 4'b0111;
    d0       = done_seen;
    wr_valid = 1'b1;
    div_val  = 24'd0;
    wr_data  = w[0];
    for (int unsigned i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      base = cyc - 1;
      arm(base, w[i], 0, 0, 1'b0);
      if (i < 2) begin
        wr_data = w[i + 1];
        repeat (7) @(posedge clk);
      end else begin
        wr_valid = 1'b0;
      end
    end
    wait_until(b_hi + 2);
    chk("b2b_done_count", done_seen - d0, 3);
    chk("b2b_drain", shift_q.size() + done_q.size() + clear_q.size(), 0);

    // reset asserted in the middle of a D=3 shift
    wr_data  = 4'b1011;
    div_val  = 24'd3;
    wr_valid = 1'b1;
    @(posedge clk);
    #1;
    base     = cyc - 1;
    wr_valid = 1'b0;
    arm(base, 4'b1011, 3, 0, 1'b0);
    wait_until(base + 8);
    mon_en = 1'b0;
    clr    = 1'b0;
    #1 reset_outputs("midrst");
    shift_q.delete();
    done_q.delete();
    clear_q.delete();
    b_lo = 1; b_hi = 0; s_lo = 1; s_hi = 0;
    exp_err = 1'b0;
    repeat (2) @(posedge clk);
    #3 clr = 1'b1;
    @(posedge clk);
    #1 mon_en = 1'b1;
    d0 = done_seen;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    chk("post_reset_no_done", done_seen - d0, 0);
    run_vec(vecs[0]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
